// File: rtl/wb_bus_decoder_pkg.sv
// Shared types and width helpers for the Wishbone bus decoder.
package calsoc_wb_pkg;

  localparam int unsigned MAX_SLAVES = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DECERR, ABORT} wbd_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_bus_decoder_if.sv
// Bundle of master-side and slave-side Wishbone signals around the decoder.
// The slave modport is the decoder's view; master is the surrounding fabric's view.
interface wb_bus_decoder_if #(
  parameter int unsigned NS = 6,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic              m_cyc_i;
  logic              m_stb_i;
  logic              m_we_i;
  logic [AW-1:0]     m_adr_i;
  logic [DW-1:0]     m_dat_i;
  logic [DW/8-1:0]   m_sel_i;
  logic              m_ack_o;
  logic              m_err_o;
  logic              m_stall_o;
  logic [DW-1:0]     m_dat_o;
  logic [NS-1:0]     s_cyc_o;
  logic [NS-1:0]     s_stb_o;
  logic              s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic [NS-1:0]     s_ack_i;
  logic [NS-1:0]     s_err_i;
  logic [NS-1:0]     s_stall_i;
  logic [NS*DW-1:0]  s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  s_ack_i, s_err_i, s_stall_i, s_dat_i,
    output m_ack_o, m_err_o, m_stall_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output s_ack_i, s_err_i, s_stall_i, s_dat_i,
    input  m_ack_o, m_err_o, m_stall_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );
endinterface

// File: rtl/wb_bus_decoder_addr_decode.sv
// Combinational address/mask decoder; the lowest matching slave index wins.
module wb_addr_decode
  import calsoc_wb_pkg::*;
#(
  parameter int unsigned        NS         = 6,
  parameter int unsigned        AW         = 32,
  parameter int unsigned        IW         = idx_width(NS),
  parameter logic [NS*AW-1:0]   SLAVE_ADDR = '0,
  parameter logic [NS*AW-1:0]   SLAVE_MASK = '0
) (
  input  logic [AW-1:0] adr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // Scanning downward lets the last (lowest) match overwrite higher ones.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = NS; i > 0; i--) begin
      if ((adr & SLAVE_MASK[(i-1)*AW +: AW]) == SLAVE_ADDR[(i-1)*AW +: AW]) begin
        hit = 1'b1;
        idx = IW'(i - 1);
      end
    end
  end

endmodule

// File: rtl/wb_bus_decoder.sv
// Single-master to NS-slave pipelined Wishbone B4 decoder with outstanding
// request tracking, decode errors and slave ack timeout.
module wb_bus_decoder
  import calsoc_wb_pkg::*;
#(
  parameter int unsigned       NS              = 6,
  parameter int unsigned       AW              = 32,
  parameter int unsigned       DW              = 32,
  parameter logic [NS*AW-1:0]  SLAVE_ADDR      = '0,
  parameter logic [NS*AW-1:0]  SLAVE_MASK      = '0,
  parameter int unsigned       MAX_OUTSTANDING = 4,
  parameter int unsigned       TIMEOUT         = 1024
) (
  input logic             clk_i,
  input logic             rst_i,
  wb_bus_decoder_if.slave bus
);

  localparam int unsigned IW = idx_width(NS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);

  wbd_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] sel_q, sel_nxt;
  logic [TW-1:0] tmr, tmr_nxt;

  logic          hit;
  logic [IW-1:0] idx;
  logic          req, acc, resp, same;
  logic [NS-1:0] s_cyc, s_stb;
  logic          m_ack, m_err, m_stall;
  logic [DW-1:0] m_dat;

  wb_addr_decode #(
    .NS(NS), .AW(AW), .IW(IW), .SLAVE_ADDR(SLAVE_ADDR), .SLAVE_MASK(SLAVE_MASK)
  ) u_decode (
    .adr(bus.m_adr_i), .hit(hit), .idx(idx)
  );

  always_comb begin
    s_cyc     = '0;
    s_stb     = '0;
    m_ack     = 1'b0;
    m_err     = 1'b0;
    m_stall   = 1'b0;
    m_dat     = '0;
    acc       = 1'b0;
    resp      = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_q;
    tmr_nxt   = '0;
    req       = bus.m_cyc_i & bus.m_stb_i;
    same      = hit && (idx == sel_q);

    case (state)
      DECERR: begin
        m_err     = 1'b1;
        m_stall   = 1'b1;
        state_nxt = IDLE;
      end
      ABORT: begin
        m_err     = 1'b1;
        m_stall   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        if (state == IDLE || cnt == '0) begin
          if (req && hit) begin
            s_cyc[idx] = 1'b1;
            s_stb[idx] = 1'b1;
            m_stall    = bus.s_stall_i[idx];
            if (!m_stall) begin
              acc       = 1'b1;
              sel_nxt   = idx;
              cnt_nxt   = CW'(1);
              state_nxt = BUSY;
            end
          end else if (req) begin
            acc       = 1'b1;
            state_nxt = DECERR;
          end
        end else begin
          s_cyc[sel_q] = bus.m_cyc_i;
          resp  = bus.m_cyc_i & (bus.s_ack_i[sel_q] | bus.s_err_i[sel_q]);
          m_err = bus.m_cyc_i & bus.s_err_i[sel_q];
          m_ack = bus.m_cyc_i & bus.s_ack_i[sel_q] & ~bus.s_err_i[sel_q];
          if (resp) m_dat = bus.s_dat_i[sel_q*DW +: DW];
          // A response in the same cycle frees a slot, so a full pipe can still accept.
          if (req && same && (cnt < CNT_MAX || resp)) begin
            s_stb[sel_q] = 1'b1;
            m_stall      = bus.s_stall_i[sel_q];
            acc          = ~m_stall;
          end else if (req) begin
            m_stall = 1'b1;
          end
          cnt_nxt = cnt + CW'(acc) - CW'(resp);
          if (cnt_nxt == '0) state_nxt = IDLE;
          if (TIMEOUT != 0 && !acc && !resp) begin
            if (tmr == TMR_LAST) state_nxt = ABORT;
            else                 tmr_nxt   = tmr + 1'b1;
          end
        end
      end
    endcase

    if (!bus.m_cyc_i) begin
      s_cyc     = '0;
      s_stb     = '0;
      cnt_nxt   = '0;
      tmr_nxt   = '0;
      state_nxt = IDLE;
    end

    if (!rst_i) begin
      s_cyc   = '0;
      s_stb   = '0;
      m_ack   = 1'b0;
      m_err   = 1'b0;
      m_stall = 1'b0;
      m_dat   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      sel_q <= '0;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sel_q <= sel_nxt;
      tmr   <= tmr_nxt;
    end
  end

  assign bus.s_cyc_o   = s_cyc;
  assign bus.s_stb_o   = s_stb;
  assign bus.m_ack_o   = m_ack;
  assign bus.m_err_o   = m_err;
  assign bus.m_stall_o = m_stall;
  assign bus.m_dat_o   = m_dat;
  assign bus.s_we_o    = bus.m_we_i;
  assign bus.s_adr_o   = bus.m_adr_i;
  assign bus.s_dat_o   = bus.m_dat_i;
  assign bus.s_sel_o   = bus.m_sel_i;

endmodule
